// File: rtl/btn_debounce_pkg.sv
// ============================================================================
// Module      : btn_debounce_pkg
// Description : Shared state encoding and counter widths for the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_debounce_pkg;

    localparam int CNT_W  = 8;
    localparam int HOLD_W = 16;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel: qualification FSM, level and pulse regs.
//               Long-press hold counter built only with BTN_DEBOUNCE_LONG_PRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = 8,
    parameter int LONG_SAMPLES   = 192
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_SAMPLES);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                RELEASED: begin
                    if (sample) begin
                        state_d = PRESS_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!sample) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_inc == STABLE_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!sample) begin
                        state_d = REL_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
                REL_PEND: begin
                    if (sample) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == STABLE_LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_SAMPLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Hold count restarts only on a fresh press; a REL_PEND bounce resumes it.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == PRESS_PEND && state_d == PRESSED) begin
            hold_d = '0;
        end else if (tick && state_q == PRESSED && hold_q != LONG_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_d == LONG_LAST);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    logic [HOLD_W-1:0] unused_long_cfg;
    assign unused_long_cfg = HOLD_W'(LONG_SAMPLES);
    assign btn_long        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Multi-channel button debouncer; synchronises inputs and the
//               clk_slow strobe. Long press via BTN_DEBOUNCE_LONG_PRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int STABLE_SAMPLES = 8,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int LONG_SAMPLES   = 192
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_slow,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam logic [N_BTN-1:0] SYNC_RST = (BTN_ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    logic [N_BTN-1:0] btn_sync1_q, btn_sync2_q;
    logic             slow_sync1_q, slow_sync2_q, slow_prev_q;
    logic             tick;
    logic [N_BTN-1:0] sample;

    // Synchronisers start at the released level so reset never looks like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_sync1_q  <= SYNC_RST;
            btn_sync2_q  <= SYNC_RST;
            slow_sync1_q <= 1'b0;
            slow_sync2_q <= 1'b0;
            slow_prev_q  <= 1'b0;
        end else begin
            btn_sync1_q  <= btn_raw;
            btn_sync2_q  <= btn_sync1_q;
            slow_sync1_q <= clk_slow;
            slow_sync2_q <= slow_sync1_q;
            slow_prev_q  <= slow_sync2_q;
        end
    end

    assign tick   = slow_sync2_q & ~slow_prev_q;
    assign sample = (BTN_ACTIVE_LOW != 0) ? ~btn_sync2_q : btn_sync2_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_SAMPLES   (LONG_SAMPLES)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .tick        (tick),
            .sample      (sample[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// Module      : tb_btn_debounce
// Description : Scoreboard bench for btn_debounce; honours BTN_DEBOUNCE_LONG_PRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;

    logic       clock = 1'b0;
    logic       reset;
    logic       clk_slow;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_long;

    btn_debounce #(
        .N_BTN          (4),
        .STABLE_SAMPLES (4),
        .BTN_ACTIVE_LOW (1),
        .LONG_SAMPLES   (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clk_slow    (clk_slow),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        int         tick;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   edge_n     = 0;
    int   rise_edge  = -100;
    int   ticks_seen = 0;
    int   phase      = 8;
    bit   stuck      = 1'b0;
    int   t_ref;

    // Reference tick: the DUT acts on the 3rd rising edge after clk_slow rises.
    initial forever begin
        @(posedge clock);
        edge_n++;
        if (reset) rise_edge = -100;
        else if (edge_n == rise_edge + 3) ticks_seen++;
    end

    // clk_slow: 16-clock period, can be forced high.
    initial begin
        logic nv;
        clk_slow = 1'b0;
        forever begin
            @(negedge clock);
            phase = (phase + 1) % 16;
            nv = stuck || (phase < 8);
            if (nv && !clk_slow) rise_edge = edge_n;
            clk_slow = nv;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (tick %0d)", name, act, exp, ticks_seen);
        end
    endtask

    // Monitor: every cycle with a pulse must match the next scoreboard entry.
    initial forever begin
        @(negedge clock);
        #1;
        if (!reset && (|btn_press || |btn_release || |btn_long)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: press=%b release=%b long=%b at tick %0d, nothing expected",
                         btn_press, btn_release, btn_long, ticks_seen);
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (ticks_seen != mon_e.tick) begin
                    n_fail++;
                    $display("FAIL pulse_tick: got tick %0d expected tick %0d", ticks_seen, mon_e.tick);
                end
                check("pulse_press",   btn_press,   mon_e.press);
                check("pulse_release", btn_release, mon_e.rel);
                check("pulse_long",    btn_long,    mon_e.lng);
                check("pulse_level",   btn_level,   mon_e.lvl);
            end
        end
    end

    task automatic wait_tick(input int n);
        int target;
        int guard;
        target = ticks_seen + n;
        guard  = 0;
        while (ticks_seen < target && guard < 64 * n + 64) begin
            @(negedge clock);
            guard++;
        end
        if (ticks_seen < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: got tick %0d expected tick %0d", ticks_seen, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got tick %0d", ticks_seen);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b1111;
        repeat (5) @(negedge clock);
        check("reset_level",   btn_level,   4'b0000);
        check("reset_press",   btn_press,   4'b0000);
        check("reset_release", btn_release, 4'b0000);
        check("reset_long",    btn_long,    4'b0000);
        reset = 1'b0;

        // Clean press on channel 0, then held long.
        wait_tick(1);
        t_ref = ticks_seen;
        btn_raw[0] = 1'b0;
        exp_q.push_back('{t_ref + 4, 4'b0001, 4'b0000, 4'b0000, 4'b0001});
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        exp_q.push_back('{t_ref + 10, 4'b0000, 4'b0000, 4'b0001, 4'b0001});
`endif
        wait_tick(4);
        check("press_level", btn_level, 4'b0001);
        wait_tick(8);

        // Bounce on channel 1: never 4 consecutive active samples.
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = (i % 2 == 1);
            repeat (20) @(negedge clock);
        end
        btn_raw[1] = 1'b1;
        wait_tick(5);
        check("bounce_level", btn_level, 4'b0001);

        // Two-tick release glitch on channel 0.
        wait_tick(1);
        btn_raw[0] = 1'b1;
        wait_tick(2);
        btn_raw[0] = 1'b0;
        wait_tick(4);
        check("glitch_level", btn_level, 4'b0001);

        // Real release on channel 0.
        t_ref = ticks_seen;
        btn_raw[0] = 1'b1;
        exp_q.push_back('{t_ref + 4, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        wait_tick(5);
        check("release_level", btn_level, 4'b0000);

        // Simultaneous press on channels 2 and 3, kept held.
        t_ref = ticks_seen;
        btn_raw[3:2] = 2'b00;
        exp_q.push_back('{t_ref + 4, 4'b1100, 4'b0000, 4'b0000, 4'b1100});
        wait_tick(4);
        check("simul_level", btn_level, 4'b1100);

        // Reset while channel 0 is two ticks into qualification.
        btn_raw[0] = 1'b0;
        wait_tick(2);
        reset = 1'b1;
        #1;
        check("midreset_level",   btn_level,   4'b0000);
        check("midreset_press",   btn_press,   4'b0000);
        check("midreset_release", btn_release, 4'b0000);
        repeat (8) @(negedge clock);
        reset = 1'b0;
        t_ref = ticks_seen;
        exp_q.push_back('{t_ref + 4, 4'b1101, 4'b0000, 4'b0000, 4'b1101});
        wait_tick(4);
        check("requalify_level", btn_level, 4'b1101);

        // clk_slow stuck high: channel 1 held active must not advance.
        t_ref = ticks_seen;
        stuck = 1'b1;
        btn_raw[1] = 1'b0;
        repeat (64) @(negedge clock);
        check("stuck_level", btn_level, 4'b1101);
        stuck = 1'b0;
        exp_q.push_back('{t_ref + 4, 4'b0010, 4'b0000, 4'b0000, 4'b1111});
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        exp_q.push_back('{t_ref + 6, 4'b0000, 4'b0000, 4'b1101, 4'b1111});
        exp_q.push_back('{t_ref + 10, 4'b0000, 4'b0000, 4'b0010, 4'b1111});
`endif
        wait_tick(12);
        check("final_level", btn_level, 4'b1111);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: got %0d entries left expected 0, next tick %0d",
                     exp_q.size(), exp_q[0].tick);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
